// File: rtl/axis_top_pkg.sv
// Shared constants, state encoding and the Q8.8 rescale/saturate helper for the
// AXI4-Stream matrix-multiply block.
package axis_top_pkg;

    localparam int DW        = 16;
    localparam int FRAC      = 8;
    localparam int K         = 8;
    localparam int N         = 4;
    localparam int M_MAX     = 16;
    localparam int I_TDATA_W = 1088;
    localparam int W_TDATA_W = 64;
    localparam int O_TDATA_W = 1088;

    localparam int ACC_W   = 2*DW + $clog2(K) + 1;
    localparam int M_CNT_W = $clog2(M_MAX + 1);
    localparam int M_IDX_W = $clog2(M_MAX);
    localparam int K_CNT_W = $clog2(K + 1);

    localparam logic signed [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_Q_MAX = {{(ACC_W-DW){1'b0}}, Q_MAX};
    localparam logic signed [ACC_W-1:0] ACC_Q_MIN = {{(ACC_W-DW){1'b1}}, Q_MIN};

    typedef enum logic {
        ST_LOAD    = 1'b0,
        ST_COMPUTE = 1'b1
    } state_e;

    // Arithmetic shift floors toward -inf; the clamp happens after rescaling.
    function automatic logic [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > ACC_Q_MAX)
            return Q_MAX;
        else if (sh < ACC_Q_MIN)
            return Q_MIN;
        else
            return sh[DW-1:0];
    endfunction

endpackage

// File: rtl/axis_top_mac.sv
// N-wide dot product of one A row against the whole W buffer; W rows whose
// mask bit is clear contribute zero.
module mac_row
    import axis_top_pkg::*;
(
    input  logic [K*DW-1:0]   i_a_row,
    input  logic [K*N*DW-1:0] i_w_flat,
    input  logic [K-1:0]      i_k_mask,
    output logic [N*DW-1:0]   o_c_row
);

    logic signed [2*DW-1:0]  w_a_ext;
    logic signed [2*DW-1:0]  w_w_ext;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_acc;

    always_comb begin
        o_c_row = '0;
        w_a_ext = '0;
        w_w_ext = '0;
        w_prod  = '0;
        w_acc   = '0;
        for (int n = 0; n < N; n++) begin
            w_acc = '0;
            for (int k = 0; k < K; k++) begin
                w_a_ext = (2*DW)'($signed(i_a_row[k*DW +: DW]));
                w_w_ext = (2*DW)'($signed(i_w_flat[(k*N+n)*DW +: DW]));
                w_prod  = w_a_ext * w_w_ext;
                if (i_k_mask[k])
                    w_acc = w_acc + ACC_W'(w_prod);
            end
            o_c_row[n*DW +: DW] = sat_shift(w_acc);
        end
    end

endmodule

// File: rtl/axis_top.sv
// Loads A and W concurrently over two AXIS slaves, then streams C = A x W one row
// per beat. o_dbg_state exposes the LOAD/COMPUTE state.
module axis_top
    import axis_top_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    output logic                 s_axis_i_tready,
    input  logic [I_TDATA_W-1:0] s_axis_i_tdata,
    input  logic                 s_axis_i_tvalid,
    input  logic                 s_axis_i_tlast,
    output logic                 s_axis_w_tready,
    input  logic [W_TDATA_W-1:0] s_axis_w_tdata,
    input  logic                 s_axis_w_tvalid,
    input  logic                 s_axis_w_tlast,
    input  logic                 m_axis_tready,
    output logic [O_TDATA_W-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output state_e               o_dbg_state
);

    // Valid/ready: a beat transfers on a rising edge where valid and ready are
    // both high; the master holds tdata/tlast/tvalid until that edge.
    state_e               r_state;
    logic [M_CNT_W-1:0]   r_m_cnt;
    logic [M_CNT_W-1:0]   r_row;
    logic [K_CNT_W-1:0]   r_k_cnt;
    logic                 r_i_done;
    logic                 r_w_done;
    logic                 r_tvalid;
    logic                 r_tlast;
    logic [N*DW-1:0]      r_tdata;
    logic [K*DW-1:0]      r_a_buf [M_MAX];
    logic [N*DW-1:0]      r_w_buf [K];

    logic                 w_i_hs;
    logic                 w_w_hs;
    logic                 w_finish;
    logic                 w_last_row;
    logic [K-1:0]         w_k_mask;
    logic [K*N*DW-1:0]    w_w_flat;
    logic [N*DW-1:0]      w_c_row;
    logic                 w_unused_i_hi;

    assign s_axis_i_tready = (r_state == ST_LOAD) && !r_i_done;
    assign s_axis_w_tready = (r_state == ST_LOAD) && !r_w_done;
    assign w_i_hs          = s_axis_i_tvalid && s_axis_i_tready;
    assign w_w_hs          = s_axis_w_tvalid && s_axis_w_tready;
    assign w_last_row      = (r_row + 1'b1 == r_m_cnt);
    assign w_finish        = (r_tvalid && r_tlast) || (r_row >= r_m_cnt);
    assign w_unused_i_hi   = ^s_axis_i_tdata[I_TDATA_W-1:K*DW];

    assign m_axis_tdata  = {{(O_TDATA_W-N*DW){1'b0}}, r_tdata};
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign o_dbg_state   = r_state;

    always_comb begin
        w_k_mask = '0;
        w_w_flat = '0;
        for (int k = 0; k < K; k++) begin
            w_k_mask[k] = (K_CNT_W'(k) < r_k_cnt);
            w_w_flat[k*N*DW +: N*DW] = r_w_buf[k];
        end
    end

    // Rows past capacity are handshaken but never stored.
    always_ff @(posedge aclk) begin
        if (w_i_hs && (r_m_cnt < M_CNT_W'(M_MAX)))
            r_a_buf[r_m_cnt[M_IDX_W-1:0]] <= s_axis_i_tdata[K*DW-1:0];
        if (w_w_hs && (r_k_cnt < K_CNT_W'(K)))
            r_w_buf[r_k_cnt[K_CNT_W-2:0]] <= s_axis_w_tdata[N*DW-1:0];
    end

    mac_row u_mac_row (
        .i_a_row  (r_a_buf[r_row[M_IDX_W-1:0]]),
        .i_w_flat (w_w_flat),
        .i_k_mask (w_k_mask),
        .o_c_row  (w_c_row)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_LOAD;
            r_m_cnt  <= '0;
            r_k_cnt  <= '0;
            r_row    <= '0;
            r_i_done <= 1'b0;
            r_w_done <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_i_hs) begin
                        if (r_m_cnt < M_CNT_W'(M_MAX))
                            r_m_cnt <= r_m_cnt + 1'b1;
                        if (s_axis_i_tlast)
                            r_i_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        if (r_k_cnt < K_CNT_W'(K))
                            r_k_cnt <= r_k_cnt + 1'b1;
                        if (s_axis_w_tlast)
                            r_w_done <= 1'b1;
                    end
                    if (r_i_done && r_w_done) begin
                        r_state <= ST_COMPUTE;
                        r_row   <= '0;
                    end
                end
                ST_COMPUTE: begin
                    // Output register is refilled whenever it is empty or draining.
                    if (!r_tvalid || m_axis_tready) begin
                        if (w_finish) begin
                            r_state  <= ST_LOAD;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_m_cnt  <= '0;
                            r_k_cnt  <= '0;
                            r_row    <= '0;
                            r_i_done <= 1'b0;
                            r_w_done <= 1'b0;
                        end else begin
                            r_tdata  <= w_c_row;
                            r_tvalid <= 1'b1;
                            r_tlast  <= w_last_row;
                            r_row    <= r_row + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_top.sv
// Directed bench for axis_top: vector table of single-row jobs plus hand-written
// multi-row, backpressure, overflow and mid-compute reset sequences.
module tb_axis_top;
    import axis_top_pkg::*;

    logic                 aclk;
    logic                 aresetn;
    logic                 s_axis_i_tready;
    logic [I_TDATA_W-1:0] s_axis_i_tdata;
    logic                 s_axis_i_tvalid;
    logic                 s_axis_i_tlast;
    logic                 s_axis_w_tready;
    logic [W_TDATA_W-1:0] s_axis_w_tdata;
    logic                 s_axis_w_tvalid;
    logic                 s_axis_w_tlast;
    logic                 m_axis_tready;
    logic [O_TDATA_W-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    state_e               o_dbg_state;

    int n_vec  = 0;
    int n_fail = 0;
    logic [N*DW:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] a_val;
        logic [DW-1:0] w_val;
        int            w_rows;
        logic [DW-1:0] exp_val;
    } vec_t;
    vec_t vecs[8];

    axis_top dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_i_tready (s_axis_i_tready),
        .s_axis_i_tdata  (s_axis_i_tdata),
        .s_axis_i_tvalid (s_axis_i_tvalid),
        .s_axis_i_tlast  (s_axis_i_tlast),
        .s_axis_w_tready (s_axis_w_tready),
        .s_axis_w_tdata  (s_axis_w_tdata),
        .s_axis_w_tvalid (s_axis_w_tvalid),
        .s_axis_w_tlast  (s_axis_w_tlast),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .o_dbg_state     (o_dbg_state)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // drivers
    task automatic drive_a(input logic [K*DW-1:0] rows[$], input bit gaps);
        int wait_cyc;
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge aclk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axis_i_tvalid = 1'b0;
                @(negedge aclk);
            end
            s_axis_i_tvalid = 1'b1;
            s_axis_i_tdata  = {{(I_TDATA_W-K*DW){1'b1}}, rows[i]};
            s_axis_i_tlast  = (i == rows.size() - 1);
            wait_cyc = 0;
            while (!s_axis_i_tready && wait_cyc < 100) begin
                @(negedge aclk);
                wait_cyc++;
            end
            if (!s_axis_i_tready) begin
                check("a_tready_timeout", s_axis_i_tready, 1);
                break;
            end
            @(posedge aclk);
        end
        @(negedge aclk);
        s_axis_i_tvalid = 1'b0;
        s_axis_i_tlast  = 1'b0;
    endtask

    task automatic drive_w(input logic [N*DW-1:0] rows[$], input bit gaps);
        int wait_cyc;
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge aclk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axis_w_tvalid = 1'b0;
                @(negedge aclk);
            end
            s_axis_w_tvalid = 1'b1;
            s_axis_w_tdata  = W_TDATA_W'(rows[i]);
            s_axis_w_tlast  = (i == rows.size() - 1);
            wait_cyc = 0;
            while (!s_axis_w_tready && wait_cyc < 100) begin
                @(negedge aclk);
                wait_cyc++;
            end
            if (!s_axis_w_tready) begin
                check("w_tready_timeout", s_axis_w_tready, 1);
                break;
            end
            @(posedge aclk);
        end
        @(negedge aclk);
        s_axis_w_tvalid = 1'b0;
        s_axis_w_tlast  = 1'b0;
    endtask

    task automatic load_job(input logic [K*DW-1:0] a_rows[$], input logic [N*DW-1:0] w_rows[$],
                            input bit gaps);
        fork
            drive_a(a_rows, gaps);
            drive_w(w_rows, gaps);
        join
    endtask

    // scoreboard: drains n_rows beats against exp_q
    task automatic collect(input int n_rows, input bit rnd);
        int beats = 0;
        int cycles = 0;
        int n_last = 0;
        bit stalled = 0;
        logic [N*DW-1:0] held_d = '0;
        logic held_l = 1'b0;
        logic [N*DW:0] exp_v;
        while (beats < n_rows && cycles < 600) begin
            @(negedge aclk);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata[N*DW-1:0], held_d);
                check("hold_last", m_axis_tlast, held_l);
            end
            if (m_axis_tvalid)
                check("in_ready_in_compute", {s_axis_i_tready, s_axis_w_tready}, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                exp_v = exp_q.pop_front();
                check("row_data", m_axis_tdata[N*DW-1:0], exp_v[N*DW-1:0]);
                check("row_last", m_axis_tlast, exp_v[N*DW]);
                check("tdata_upper", {63'b0, |m_axis_tdata[O_TDATA_W-1:N*DW]}, 0);
                if (m_axis_tlast) n_last++;
                beats++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held_d  = m_axis_tdata[N*DW-1:0];
            held_l  = m_axis_tlast;
            cycles++;
        end
        check("beat_count", beats, n_rows);
        check("tlast_count", n_last, 1);
        check("exp_q_empty", exp_q.size(), 0);
        @(negedge aclk);
        check("idle_after_job", {m_axis_tvalid, s_axis_i_tready, s_axis_w_tready}, 3'b011);
        check("state_after_job", o_dbg_state, ST_LOAD);
    endtask

    task automatic run_vec(input int idx);
        logic [K*DW-1:0] a_rows[$];
        logic [N*DW-1:0] w_rows[$];
        a_rows.push_back({K{vecs[idx].a_val}});
        for (int i = 0; i < vecs[idx].w_rows; i++)
            w_rows.push_back({N{vecs[idx].w_val}});
        exp_q.push_back({1'b1, {N{vecs[idx].exp_val}}});
        fork
            load_job(a_rows, w_rows, 1'b0);
            collect(1, 1'b0);
        join
    endtask

    task automatic mixed_job(input bit rnd);
        logic [K*DW-1:0] a_rows[$];
        logic [N*DW-1:0] w_rows[$];
        a_rows.push_back({16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0100});
        a_rows.push_back({K{16'h0080}});
        a_rows.push_back({K{16'hFF00}});
        a_rows.push_back({16'hFF00, {6{16'h0000}}, 16'h0300});
        for (int i = 0; i < K; i++)
            w_rows.push_back({16'h0200, 16'h0200, 16'h0100, 16'h0100});
        exp_q.push_back({1'b0, 16'h1800, 16'h1800, 16'h0C00, 16'h0C00});
        exp_q.push_back({1'b0, 16'h0800, 16'h0800, 16'h0400, 16'h0400});
        exp_q.push_back({1'b0, 16'hF000, 16'hF000, 16'hF800, 16'hF800});
        exp_q.push_back({1'b1, 16'h0400, 16'h0400, 16'h0200, 16'h0200});
        fork
            load_job(a_rows, w_rows, rnd);
            collect(4, rnd);
        join
    endtask

    initial begin
        logic [K*DW-1:0] a_rows[$];
        logic [N*DW-1:0] w_rows[$];
        int wait_cyc;

        vecs[0] = '{16'h0100, 16'h0100, 8, 16'h0800};
        vecs[1] = '{16'h0100, 16'h0100, 6, 16'h0600};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 8, 16'h7FFF};
        vecs[3] = '{16'hFF00, 16'h0100, 8, 16'hF800};
        vecs[4] = '{16'h8000, 16'h7FFF, 8, 16'h8000};
        vecs[5] = '{16'h0080, 16'h0200, 3, 16'h0300};
        vecs[6] = '{16'h0001, 16'h0001, 8, 16'h0000};
        vecs[7] = '{16'hFFFF, 16'h0001, 8, 16'hFFFF};

        aresetn         = 1'b0;
        s_axis_i_tvalid = 1'b0;
        s_axis_i_tlast  = 1'b0;
        s_axis_i_tdata  = '0;
        s_axis_w_tvalid = 1'b0;
        s_axis_w_tlast  = 1'b0;
        s_axis_w_tdata  = '0;
        m_axis_tready   = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata[63:0], 0);
        check("rst_i_tready", s_axis_i_tready, 1);
        check("rst_w_tready", s_axis_w_tready, 1);
        check("rst_state", o_dbg_state, ST_LOAD);
        aresetn = 1'b1;

        for (int v = 0; v < 8; v++)
            run_vec(v);

        mixed_job(1'b0);
        mixed_job(1'b1);

        // 17 A rows: the last one is handshaken but dropped
        for (int i = 0; i < M_MAX + 1; i++)
            a_rows.push_back({K{16'h0100}});
        for (int i = 0; i < K; i++)
            w_rows.push_back({N{16'h0100}});
        for (int i = 0; i < M_MAX; i++)
            exp_q.push_back({(i == M_MAX - 1), {N{16'h0800}}});
        fork
            load_job(a_rows, w_rows, 1'b0);
            collect(M_MAX, 1'b0);
        join

        // reset while a result is stalled on the master port
        a_rows.delete();
        w_rows.delete();
        for (int i = 0; i < 4; i++)
            a_rows.push_back({K{16'h0100}});
        for (int i = 0; i < K; i++)
            w_rows.push_back({N{16'h0100}});
        m_axis_tready = 1'b0;
        load_job(a_rows, w_rows, 1'b0);
        wait_cyc = 0;
        while (!m_axis_tvalid && wait_cyc < 50) begin
            @(negedge aclk);
            wait_cyc++;
        end
        check("pre_rst_tvalid", m_axis_tvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tdata", m_axis_tdata[63:0], 0);
        check("midrst_treadys", {s_axis_i_tready, s_axis_w_tready}, 2'b11);
        check("midrst_state", o_dbg_state, ST_LOAD);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_treadys", {s_axis_i_tready, s_axis_w_tready}, 2'b11);
        run_vec(0);
        run_vec(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
